eco32f_decode: RTL
==================

# eco32f_decode

Instruction decode stage of the eco32f pipeline, directly downstream of the fetch stage. It consumes the fetch stage's registered `id_pc`/`id_insn` and exception flags, plus register-file read data addressed by fetch one cycle earlier. It produces a registered, fully decoded execute-stage bundle. It also owns load-use hazard detection and holds operands stable across stalls.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_stall`  in  1  external stall (downstream/bus); hold ID and EX registers
- `id_flush`  in  1  kill instruction in ID; inject bubble into EX
- `id_pc`  in  32  PC of instruction in ID
- `id_insn`  in  32  instruction word in ID
- `id_exc_ibus_fault`, `id_exc_itlb_kmiss`, `id_exc_itlb_umiss`, `id_exc_itlb_invalid`, `id_exc_itlb_priv`  in  1 each  fetch exception flags
- `rf_x_data`, `rf_y_data`  in  32 each  RF read data, valid the cycle the instruction enters ID
- `wb_we`  in  1  writeback enable
- `wb_addr`  in  5  writeback register
- `wb_data`  in  32  writeback data
- `id_hazard`  out  1  combinational load-use stall request to fetch
- `ex_pc`, `ex_insn`  out  32 each  registered PC and instruction
- `ex_op`  out  6  opcode `insn[31:26]`
- `ex_rf_x`, `ex_rf_y`  out  32 each  operand values
- `ex_imm`  out  32  extended immediate
- `ex_dest_addr`  out  5  destination register
- `ex_dest_we`  out  1  writes a register
- `ex_load`, `ex_store`, `ex_branch`, `ex_jump`  out  1 each  class flags
- `ex_exc_*` (5 fetch flags) + `ex_exc_illegal`  out  1 each  exceptions

## Operation
- Fields: rx=`insn[25:21]` (30 for RFX), ry=`insn[20:16]`, rz=`insn[15:11]`, imm16=`insn[15:0]`, off26=`insn[25:0]`.
- Destination: RRR format → rz; RRI/load → ry; JAL/JALR → 31. `ex_dest_we` is forced 0 when the destination is 0.
- Immediate:
  - arithmetic/load/store: sign-extend imm16
  - logical (AND/OR/XOR-I): zero-extend imm16
  - LDHI: `{imm16,16'h0}`
  - conditional branch: sign-extend(imm16)<<2
  - J/JAL: sign-extend(off26)<<2
- Unknown opcode → `ex_exc_illegal`=1, but only when no fetch exception flag is set. Fetch flags pass through unchanged.
- Load-use hazard: `id_hazard` = `ex_load & ex_dest_we & !id_flush` and (`ex_dest_addr`==rx with rx used, or ==ry with ry used).
  - When asserted, ID holds and EX receives a bubble: `ex_insn`=`ECO32F_INSN_NOP`, all class/we/exc flags 0.
- Operand hold FSM (one per operand), states RF_LIVE and RF_HELD:
  - RF_LIVE: operand = `wb_data` if `wb_we` & `wb_addr`==reg & reg≠0, else `rf_*_data`. On a cycle with (`id_stall`|`id_hazard`), capture the operand into a shadow register and move to RF_HELD.
  - RF_HELD: operand = shadow. Shadow updates from `wb_data` on a matching `wb_we` (reg≠0).
  - RF_HELD → RF_LIVE on the first cycle with no stall and no hazard; that cycle's EX capture uses the shadow.
  - `id_flush` forces RF_LIVE.
- Register 0 always reads 0.

## Timing
- Latency is 1 cycle, ID→EX registered.
- Priority: `rst` > `id_flush` > `id_stall` > `id_hazard` > advance.
- Flush or reset: EX bundle becomes a bubble and `ex_pc` becomes 0. This applies even when `id_stall` is asserted simultaneously.
- `id_stall`: all EX outputs hold their values.
- Hazard without stall: bubble into EX for exactly one cycle. `id_hazard` then deasserts because `ex_load`=0.
- Reset values: `ex_insn`=NOP, `ex_pc`=0, every other EX output 0, both FSMs in RF_LIVE, shadows 0.
- Reset mid-stall or mid-hazard: state is discarded and there is no pending bubble.

## Structure
- Opcode constants, `ECO32F_INSN_NOP`, and immediate-kind encodings live in `eco32f.vh`.
- One sub-module, `eco32f_operand_hold` (hold FSM + shadow + writeback bypass), instantiated for X and Y.
- Decode tables and the immediate mux stay in `eco32f_decode`.

## Test plan
- Reset: hold `rst` 2 cycles → `ex_insn`=NOP, `ex_dest_we`=0, `id_hazard`=0.
- ADDI $3,$4,0xFFFE, `rf_x_data`=0x10 → next cycle `ex_imm`=0xFFFFFFFE, `ex_dest_addr`=3, `ex_rf_x`=0x10. ORI with imm 0x8000 → `ex_imm`=0x00008000.
- LDW $5,… followed by ADD $6,$5,$1 → `id_hazard`=1 for one cycle, one NOP in EX, then ADD reaches EX with `ex_rf_x` = the $5 value written back via `wb_*`.
- Stall 3 cycles with `rf_x_data` changing to 0xDEAD after the first cycle, plus `wb_we` to rx=7 with 0x1234 in cycle 2 → released instruction carries `ex_rf_x`=0x1234. Without the writeback, it carries the originally captured value.
- `id_flush` together with `id_stall` → EX becomes a bubble next cycle. Undefined opcode with `id_exc_itlb_kmiss`=1 → `ex_exc_itlb_kmiss`=1, `ex_exc_illegal`=0.
- JAL off26=0x3FFFFFF → `ex_imm`=0xFFFFFFFC, `ex_dest_addr`=31, `ex_jump`=1. ADD to $0 → `ex_dest_we`=0.

Source files
------------

// File: rtl/eco32f_decode_pkg.sv
// Shared eco32f decode definitions: opcodes, NOP encoding, immediate kinds,
// operand-hold FSM states and the registered ID->EX bundle layout.
// Pure declarations; no logic, no latency, no flow control.
package eco32f_decode_pkg;

  // ADD $0,$0,$0 -- architecturally a no-op, all-zero encoding
  localparam logic [31:0] ECO32F_INSN_NOP = 32'h0000_0000;

  // Opcode map (insn[31:26]); 0x00..0x1D are the ALU RRR/RRI pairs
  localparam logic [5:0] OP_ANDI  = 6'h11;
  localparam logic [5:0] OP_ORI   = 6'h13;
  localparam logic [5:0] OP_XORI  = 6'h15;
  localparam logic [5:0] OP_XNORI = 6'h17;
  localparam logic [5:0] OP_SARI  = 6'h1D;
  localparam logic [5:0] OP_LDHI  = 6'h1F;
  localparam logic [5:0] OP_BEQ   = 6'h20;
  localparam logic [5:0] OP_BGTU  = 6'h29;
  localparam logic [5:0] OP_J     = 6'h2A;
  localparam logic [5:0] OP_JR    = 6'h2B;
  localparam logic [5:0] OP_JAL   = 6'h2C;
  localparam logic [5:0] OP_JALR  = 6'h2D;
  localparam logic [5:0] OP_TRAP  = 6'h2E;
  localparam logic [5:0] OP_RFX   = 6'h2F;
  localparam logic [5:0] OP_LDW   = 6'h30;
  localparam logic [5:0] OP_LDBU  = 6'h34;
  localparam logic [5:0] OP_STW   = 6'h35;
  localparam logic [5:0] OP_STB   = 6'h37;
  localparam logic [5:0] OP_MVFS  = 6'h38;
  localparam logic [5:0] OP_MVTS  = 6'h39;
  localparam logic [5:0] OP_TBS   = 6'h3A;
  localparam logic [5:0] OP_TBWI  = 6'h3D;

  localparam logic [4:0] REG_LINK = 5'd31;  // JAL/JALR return address
  localparam logic [4:0] REG_XRET = 5'd30;  // RFX exception return address

  typedef enum logic [2:0] {
    IMM_SEXT,    // sign-extended imm16
    IMM_ZEXT,    // zero-extended imm16
    IMM_HIGH,    // imm16 in the upper half
    IMM_BRANCH,  // sign-extended imm16, word offset
    IMM_JUMP     // sign-extended off26, word offset
  } imm_kind_t;

  typedef enum logic {RF_LIVE, RF_HELD} rf_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [5:0]  op;
    logic [31:0] rf_x;
    logic [31:0] rf_y;
    logic [31:0] imm;
    logic [4:0]  dest_addr;
    logic        dest_we;
    logic        load;
    logic        store;
    logic        branch;
    logic        jump;
    logic        exc_ibus_fault;
    logic        exc_itlb_kmiss;
    logic        exc_itlb_umiss;
    logic        exc_itlb_invalid;
    logic        exc_itlb_priv;
    logic        exc_illegal;
  } ex_bundle_t;

  function automatic ex_bundle_t ex_bubble();
    ex_bubble      = '0;
    ex_bubble.insn = ECO32F_INSN_NOP;
  endfunction

endpackage

// File: rtl/eco32f_operand_hold.sv
// One register operand for ID: writeback bypass plus a shadow that freezes the
// operand while ID is held. Ports: clk/rst, flush/hold control, reg_addr,
// rf_data, wb_we/wb_addr/wb_data, operand (combinational, valid every cycle).
module eco32f_operand_hold
  import eco32f_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] rf_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] operand
);

  rf_state_t   state, state_nxt;
  logic [31:0] shadow;
  logic [31:0] live_val;
  logic        wb_hit;

  assign wb_hit = wb_we && (wb_addr == reg_addr) && (reg_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= RF_LIVE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RF_LIVE;
    end else begin
      case (state)
        RF_LIVE: if (hold)  state_nxt = RF_HELD;
        RF_HELD: if (!hold) state_nxt = RF_LIVE;
        default: state_nxt = RF_LIVE;
      endcase
    end
  end

  always_comb begin
    if (reg_addr == 5'd0) live_val = 32'h0;
    else if (wb_hit)      live_val = wb_data;
    else                  live_val = rf_data;
    operand = (state == RF_HELD) ? shadow : live_val;
  end

  // Capture on entry to HELD; afterwards only writebacks to this register can
  // change it, since the RF read port has moved on to younger instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 32'h0;
    end else if (state == RF_LIVE && hold && !flush) begin
      shadow <= live_val;
    end else if (state == RF_HELD && wb_hit) begin
      shadow <= wb_data;
    end
  end

endmodule

// File: rtl/eco32f_decode.sv
// eco32f ID stage: decodes id_insn into a registered EX bundle, detects load-use.
// Latency 1 cycle ID->EX. id_stall holds EX; id_hazard inserts one bubble.
// Ports: clk/rst, id_stall/id_flush, id_* fetch bundle, rf_*_data, wb_*, id_hazard, ex_*.
module eco32f_decode
  import eco32f_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        id_flush,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_insn,
  input  logic        id_exc_ibus_fault,
  input  logic        id_exc_itlb_kmiss,
  input  logic        id_exc_itlb_umiss,
  input  logic        id_exc_itlb_invalid,
  input  logic        id_exc_itlb_priv,
  input  logic [31:0] rf_x_data,
  input  logic [31:0] rf_y_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_hazard,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_insn,
  output logic [5:0]  ex_op,
  output logic [31:0] ex_rf_x,
  output logic [31:0] ex_rf_y,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest_addr,
  output logic        ex_dest_we,
  output logic        ex_load,
  output logic        ex_store,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_exc_ibus_fault,
  output logic        ex_exc_itlb_kmiss,
  output logic        ex_exc_itlb_umiss,
  output logic        ex_exc_itlb_invalid,
  output logic        ex_exc_itlb_priv,
  output logic        ex_exc_illegal
);

  ex_bundle_t  ex_q, dec;
  logic [5:0]  op;
  logic [4:0]  rx, ry, dest;
  logic        use_x, use_y, legal, fetch_exc;
  logic        is_load, is_store, is_branch, is_jump;
  imm_kind_t   kind;
  logic [31:0] imm, opnd_x, opnd_y;

  // ---------------------------------------------------------------- decode
  always_comb begin
    op        = id_insn[31:26];
    rx        = (op == OP_RFX) ? REG_XRET : id_insn[25:21];
    ry        = id_insn[20:16];
    use_x     = 1'b0;
    use_y     = 1'b0;
    dest      = 5'd0;
    kind      = IMM_SEXT;
    legal     = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    if (op <= OP_SARI) begin
      // ALU: even opcodes are RRR, odd ones the RRI twin
      use_x = 1'b1;
      if (!op[0]) begin
        use_y = 1'b1;
        dest  = id_insn[15:11];
      end else begin
        dest = ry;
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == OP_XNORI)
          kind = IMM_ZEXT;
      end
    end else begin
      case (op) inside
        OP_LDHI:         begin dest = ry; kind = IMM_HIGH; end
        [OP_BEQ:OP_BGTU]: begin use_x = 1'b1; use_y = 1'b1; is_branch = 1'b1; kind = IMM_BRANCH; end
        OP_J:            begin is_jump = 1'b1; kind = IMM_JUMP; end
        OP_JR:           begin is_jump = 1'b1; use_x = 1'b1; end
        OP_JAL:          begin is_jump = 1'b1; dest = REG_LINK; kind = IMM_JUMP; end
        OP_JALR:         begin is_jump = 1'b1; dest = REG_LINK; use_x = 1'b1; end
        OP_RFX:          use_x = 1'b1;
        [OP_LDW:OP_LDBU]: begin use_x = 1'b1; is_load = 1'b1; dest = ry; end
        [OP_STW:OP_STB]:  begin use_x = 1'b1; use_y = 1'b1; is_store = 1'b1; end
        OP_MVFS:         dest = ry;
        OP_MVTS:         use_y = 1'b1;
        OP_TRAP, [OP_TBS:OP_TBWI]: begin end
        default:         legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (kind)
      IMM_ZEXT:   imm = {16'h0, id_insn[15:0]};
      IMM_HIGH:   imm = {id_insn[15:0], 16'h0};
      IMM_BRANCH: imm = {{14{id_insn[15]}}, id_insn[15:0], 2'b00};
      IMM_JUMP:   imm = {{4{id_insn[25]}}, id_insn[25:0], 2'b00};
      default:    imm = {{16{id_insn[15]}}, id_insn[15:0]};
    endcase
  end

  assign fetch_exc = id_exc_ibus_fault | id_exc_itlb_kmiss | id_exc_itlb_umiss |
                     id_exc_itlb_invalid | id_exc_itlb_priv;

  // ex_dest_we already implies a non-zero destination, so $0 never stalls
  assign id_hazard = ex_q.load && ex_q.dest_we && !id_flush &&
                     ((use_x && ex_q.dest_addr == rx) || (use_y && ex_q.dest_addr == ry));

  // ------------------------------------------------------------- operands
  eco32f_operand_hold u_hold_x (
    .clk(clk), .rst(rst), .flush(id_flush), .hold(id_stall | id_hazard),
    .reg_addr(rx), .rf_data(rf_x_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .operand(opnd_x)
  );

  eco32f_operand_hold u_hold_y (
    .clk(clk), .rst(rst), .flush(id_flush), .hold(id_stall | id_hazard),
    .reg_addr(ry), .rf_data(rf_y_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .operand(opnd_y)
  );

  always_comb begin
    dec                  = '0;
    dec.pc               = id_pc;
    dec.insn             = id_insn;
    dec.op               = op;
    dec.rf_x             = opnd_x;
    dec.rf_y             = opnd_y;
    dec.imm              = imm;
    dec.dest_addr        = dest;
    dec.dest_we          = (dest != 5'd0);
    dec.load             = is_load;
    dec.store            = is_store;
    dec.branch           = is_branch;
    dec.jump             = is_jump;
    dec.exc_ibus_fault   = id_exc_ibus_fault;
    dec.exc_itlb_kmiss   = id_exc_itlb_kmiss;
    dec.exc_itlb_umiss   = id_exc_itlb_umiss;
    dec.exc_itlb_invalid = id_exc_itlb_invalid;
    dec.exc_itlb_priv    = id_exc_itlb_priv;
    dec.exc_illegal      = !legal && !fetch_exc;
  end

  // ---------------------------------------------------------- EX register
  always_ff @(posedge clk) begin
    if (rst || id_flush) ex_q <= ex_bubble();
    else if (id_stall)   ex_q <= ex_q;
    else if (id_hazard)  ex_q <= ex_bubble();
    else                 ex_q <= dec;
  end

  assign ex_pc               = ex_q.pc;
  assign ex_insn             = ex_q.insn;
  assign ex_op               = ex_q.op;
  assign ex_rf_x             = ex_q.rf_x;
  assign ex_rf_y             = ex_q.rf_y;
  assign ex_imm              = ex_q.imm;
  assign ex_dest_addr        = ex_q.dest_addr;
  assign ex_dest_we          = ex_q.dest_we;
  assign ex_load             = ex_q.load;
  assign ex_store            = ex_q.store;
  assign ex_branch           = ex_q.branch;
  assign ex_jump             = ex_q.jump;
  assign ex_exc_ibus_fault   = ex_q.exc_ibus_fault;
  assign ex_exc_itlb_kmiss   = ex_q.exc_itlb_kmiss;
  assign ex_exc_itlb_umiss   = ex_q.exc_itlb_umiss;
  assign ex_exc_itlb_invalid = ex_q.exc_itlb_invalid;
  assign ex_exc_itlb_priv    = ex_q.exc_itlb_priv;
  assign ex_exc_illegal      = ex_q.exc_illegal;

endmodule
